// File: rtl/tea_decrypt_core.sv
// Iterative TEA block decryptor: one cycle per TEA round, valid/ready on both sides.
// Optional encrypt mode is built in with `define TEA_DECRYPT_CORE_ENC_EN.
module tea_decrypt_core #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_v0,
    input  logic [31:0]  in_v1,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_v0,
    output logic [31:0]  out_v1,
    output logic         busy
`ifdef TEA_DECRYPT_CORE_ENC_EN
    ,
    input  logic         encrypt
`endif
);

    localparam logic [31:0] DELTA     = 32'h9E3779B9;
    localparam logic [63:0] SUM_PROD  = 64'(ROUNDS) * 64'(DELTA);
    localparam logic [31:0] SUM_INIT  = SUM_PROD[31:0];
    localparam logic [5:0]  LAST_RND  = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        last_rnd;
    logic [5:0]  rnd;
    logic [31:0] v0, v1, sum;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] nv0, nv1, nsum;
    logic [31:0] dv0, dv1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (rnd == LAST_RND) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_rnd = (state == ROUND) && (rnd == LAST_RND);

    // Decrypt round: v1 is unwound first, and the new v1 feeds the v0 update.
    always_comb begin
        dv1 = v1 - ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
        dv0 = v0 - ((((dv1 << 4) + k0) ^ (dv1 + sum)) ^ ((dv1 >> 5) + k1));
    end

`ifdef TEA_DECRYPT_CORE_ENC_EN
    logic        enc_q;
    logic [31:0] esum, ev0, ev1;

    // Encrypt round: sum advances before use, v0 updated first.
    always_comb begin
        esum = sum + DELTA;
        ev0  = v0 + ((((v1 << 4) + k0) ^ (v1 + esum)) ^ ((v1 >> 5) + k1));
        ev1  = v1 + ((((ev0 << 4) + k2) ^ (ev0 + esum)) ^ ((ev0 >> 5) + k3));
        nv0  = enc_q ? ev0  : dv0;
        nv1  = enc_q ? ev1  : dv1;
        nsum = enc_q ? esum : (sum - DELTA);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     enc_q <= 1'b0;
        else if (accept) enc_q <= encrypt;
    end
`else
    always_comb begin
        nv0  = dv0;
        nv1  = dv1;
        nsum = sum - DELTA;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v0     <= '0;
            v1     <= '0;
            sum    <= '0;
            rnd    <= '0;
            k0     <= '0;
            k1     <= '0;
            k2     <= '0;
            k3     <= '0;
            out_v0 <= '0;
            out_v1 <= '0;
        end else if (accept) begin
            v0  <= in_v0;
            v1  <= in_v1;
            k0  <= key[31:0];
            k1  <= key[63:32];
            k2  <= key[95:64];
            k3  <= key[127:96];
            rnd <= '0;
`ifdef TEA_DECRYPT_CORE_ENC_EN
            sum <= encrypt ? '0 : SUM_INIT;
`else
            sum <= SUM_INIT;
`endif
        end else if (state == ROUND) begin
            v0  <= nv0;
            v1  <= nv1;
            sum <= nsum;
            rnd <= rnd + 6'd1;
            // Result registers only change on completion so they keep the last block afterwards.
            if (last_rnd) begin
                out_v0 <= nv0;
                out_v1 <= nv1;
            end
        end
    end

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Directed bench for tea_decrypt_core: reference TEA model plus a per-cycle handshake/result compare.
module tb_tea_decrypt_core;

    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_v0 = '0;
    logic [31:0]  in_v1 = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_v0;
    logic [31:0]  out_v1;
    logic         busy;
    logic         encrypt = 1'b0;

    int checks = 0;
    int errors = 0;

    tea_decrypt_core #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_v0     (in_v0),
        .in_v1     (in_v1),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v0    (out_v0),
        .out_v1    (out_v1),
        .busy      (busy)
`ifdef TEA_DECRYPT_CORE_ENC_EN
        ,
        .encrypt   (encrypt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_dec(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [127:0] k);
        logic [31:0] y, z, s;
        y = c0;
        z = c1;
        s = 32'(ROUNDS) * DELTA;
        for (int i = 0; i < ROUNDS; i++) begin
            z = z - ((((y << 4) + k[95:64]) ^ (y + s)) ^ ((y >> 5) + k[127:96]));
            y = y - ((((z << 4) + k[31:0]) ^ (z + s)) ^ ((z >> 5) + k[63:32]));
            s = s - DELTA;
        end
        return {y, z};
    endfunction

    function automatic logic [63:0] model_enc(input logic [31:0] p0, input logic [31:0] p1,
                                              input logic [127:0] k);
        logic [31:0] y, z, s;
        y = p0;
        z = p1;
        s = '0;
        for (int i = 0; i < ROUNDS; i++) begin
            s = s + DELTA;
            y = y + ((((z << 4) + k[31:0]) ^ (z + s)) ^ ((z >> 5) + k[63:32]));
            z = z + ((((y << 4) + k[95:64]) ^ (y + s)) ^ ((y >> 5) + k[127:96]));
        end
        return {y, z};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level expectation: 0 = waiting for a block, 1 = rounds running, 2 = result offered.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [63:0] m_res   = '0;
    logic [63:0] m_last  = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase = 0;
            m_left  = 0;
            m_last  = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   = encrypt ? model_enc(in_v0, in_v1, key) : model_dec(in_v0, in_v1, key);
                    m_phase = 1;
                    m_left  = ROUNDS;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_last  = m_res;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready",  {31'b0, in_ready},  {31'b0, m_phase == 0});
        check("busy",      {31'b0, busy},      {31'b0, m_phase == 1});
        check("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
        check("out_v0",    out_v0, m_last[63:32]);
        check("out_v1",    out_v1, m_last[31:0]);
    end

    // Entered and left at posedge+2.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [127:0] k,
                        input bit hold);
        int t;
        t = 0;
        in_v0    = a;
        in_v1    = b;
        key      = k;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("accept_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        if (!hold) in_valid = 1'b0;
    endtask

    // Counts edges from the acceptance edge until out_valid; leaves at posedge+2.
    task automatic wait_out(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check("out_wait", {31'b0, out_valid}, 32'd1);
        #1;
    endtask

    localparam logic [31:0]  CT0  = 32'h41EA3A0A;
    localparam logic [31:0]  CT1  = 32'h94BAA940;
    localparam logic [127:0] KA   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] KB   = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
    localparam logic [127:0] KC   = 128'h0000_0001_0000_0002_0000_0003_0000_0004;

    initial begin
        int          n;
        logic [63:0] r;

        r = model_dec(CT0, CT1, '0);
        check("pin_dec_v0", r[63:32], 32'h0);
        check("pin_dec_v1", r[31:0],  32'h0);
        r = model_enc(32'h0, 32'h0, '0);
        check("pin_enc_v0", r[63:32], CT0);
        check("pin_enc_v1", r[31:0],  CT1);

        #1 resetn = 1'b0;
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_out_v0",    out_v0, 32'h0);
        check("rst_out_v1",    out_v1, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;

        // Known vector, accepted on the first edge after reset release.
        out_ready = 1'b1;
        send(CT0, CT1, '0, 1'b0);
        wait_out(n);
        check("t1_latency", n, 32'd32);
        check("t1_v0", out_v0, 32'h0);
        check("t1_v1", out_v1, 32'h0);
        @(posedge clk);
        #2;

        // Consumer stalls for 10 cycles.
        out_ready = 1'b0;
        send(CT0, CT1, '0, 1'b0);
        wait_out(n);
        check("t2_latency", n, 32'd32);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            check("t2_hold_v0",     out_v0, 32'h0);
            check("t2_hold_v1",     out_v1, 32'h0);
            check("t2_hold_ready",  {31'b0, in_ready},  32'd0);
            check("t2_hold_valid",  {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_idle_ready", {31'b0, in_ready},  32'd1);
        check("t2_idle_valid", {31'b0, out_valid}, 32'd0);
        #1;

        // Reset in the middle of round 15 abandons the block.
        send(CT0 ^ 32'h1, CT1, KA, 1'b0);
        repeat (14) @(posedge clk);
        #2 resetn = 1'b0;
        #2;
        check("t3_rst_busy",  {31'b0, busy},     32'd0);
        check("t3_rst_ready", {31'b0, in_ready}, 32'd1);
        #2 resetn = 1'b1;
        for (int i = 0; i < ROUNDS + 5; i++) begin
            @(posedge clk);
            #1;
            check("t3_no_output", {31'b0, out_valid}, 32'd0);
        end
        #1;
        send(CT0, CT1, '0, 1'b0);
        wait_out(n);
        check("t3_latency", n, 32'd32);
        check("t3_v0", out_v0, 32'h0);
        check("t3_v1", out_v1, 32'h0);
        @(posedge clk);
        #2;

        // Back-to-back with in_valid held; data switched to the second block mid-flight.
        send(32'h1111_2222, 32'h3333_4444, KA, 1'b1);
        in_v0 = 32'hAAAA_5555;
        in_v1 = 32'h0F0F_F0F0;
        key   = KB;
        wait_out(n);
        r = model_dec(32'h1111_2222, 32'h3333_4444, KA);
        check("t4a_latency", n, 32'd32);
        check("t4a_v0", out_v0, r[63:32]);
        check("t4a_v1", out_v1, r[31:0]);
        @(posedge clk);
        #1;
        check("t4_gap_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("t4_second_busy", {31'b0, busy}, 32'd1);
        #1 in_valid = 1'b0;
        wait_out(n);
        r = model_dec(32'hAAAA_5555, 32'h0F0F_F0F0, KB);
        check("t4b_latency", n, 32'd32);
        check("t4b_v0", out_v0, r[63:32]);
        check("t4b_v1", out_v1, r[31:0]);
        @(posedge clk);
        #2;

        // Input noise during rounds must not disturb the in-flight block.
        send(32'hCAFE_F00D, 32'h8BAD_BEEF, KC, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            in_valid = ~in_valid;
            key      = {$urandom, $urandom, $urandom, $urandom};
            in_v0    = $urandom;
            in_v1    = $urandom;
        end
        in_valid = 1'b0;
        wait_out(n);
        r = model_dec(32'hCAFE_F00D, 32'h8BAD_BEEF, KC);
        check("t5_latency", n, 32'd27);
        check("t5_v0", out_v0, r[63:32]);
        check("t5_v1", out_v1, r[31:0]);
        @(posedge clk);
        #2;

`ifdef TEA_DECRYPT_CORE_ENC_EN
        encrypt = 1'b1;
        send(32'h0, 32'h0, '0, 1'b0);
        encrypt = 1'b0;
        wait_out(n);
        check("t6_latency", n, 32'd32);
        check("t6_v0", out_v0, CT0);
        check("t6_v1", out_v1, CT1);
        @(posedge clk);
        #2;
`endif

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
